// File: rtl/direction_input.sv
// ---------------------------------------------------------------------------
// direction_input
//
// Purpose:
//   Input side of the snake board I/O. The four direction buttons are
//   synchronised and debounced. Each debounced press becomes a one-cycle
//   pulse, and the latest press is held in a one-entry pending slot. On each
//   game-step tick that slot is committed to the snake heading.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level change
//   INIT_DIR         heading after reset (N=0, E=1, S=2, W=3)
//
// Ports:
//   clk          in   1  system clock, single domain
//   rst          in   1  synchronous active-high reset
//   btn_raw      in   4  asynchronous buttons, active-high [0]=N [1]=E [2]=S [3]=W
//   tick         in   1  one-cycle game-step strobe; commits the pending press
//   btn_state    out  4  debounced button levels
//   press        out  4  one-cycle pulse per button on its debounced rising edge
//   dir          out  2  current committed heading
//   dir_changed  out  1  one-cycle pulse after a commit that changed dir
//
// Configuration macro:
//   DIR_REVERSAL_BLOCK_EN  when defined, a pending 180-degree reversal is
//                          discarded at commit (slot still clears).
// ---------------------------------------------------------------------------
module direction_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter logic [1:0]  INIT_DIR        = 2'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       tick,
  output logic [3:0] btn_state,
  output logic [3:0] press,
  output logic [1:0] dir,
  output logic       dir_changed
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       state_q, state_d;
  logic [3:0]       state_prev_q, state_prev_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press_q, press_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_dir_q, pend_dir_d;
  logic [1:0]       dir_q, dir_d;
  logic             dir_changed_q, dir_changed_d;

  logic             take_valid;
  logic [1:0]       take_dir;
  logic             rev_blocked;
  logic             commit;

  // Two-stage synchroniser; only sync2 is used downstream.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: the counter tracks how long sync has disagreed with
  // the accepted level; the level flips on the DEBOUNCE_CYCLES-th
  // consecutive disagreeing cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        state_d[i] = ~state_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Registered rising-edge pulse, one cycle after btn_state rises.
  always_comb begin
    state_prev_d = state_q;
    press_d      = state_q & ~state_prev_q;
  end

  // Press arbitration, priority N > E > S > W.
  always_comb begin
    take_valid = |press_q;
    take_dir   = 2'd0;
    if (press_q[0]) begin
      take_dir = 2'd0;
    end else if (press_q[1]) begin
      take_dir = 2'd1;
    end else if (press_q[2]) begin
      take_dir = 2'd2;
    end else if (press_q[3]) begin
      take_dir = 2'd3;
    end
  end

`ifdef DIR_REVERSAL_BLOCK_EN
  assign rev_blocked = (pend_dir_q == (dir_q ^ 2'b10));
`else
  assign rev_blocked = 1'b0;
`endif

  // Commit uses the slot as it stood before this edge; a press arriving in
  // the same cycle refills the slot afterwards and waits for the next tick.
  always_comb begin
    commit        = tick && pend_valid_q && !rev_blocked;
    dir_d         = commit ? pend_dir_q : dir_q;
    dir_changed_d = commit && (pend_dir_q != dir_q);
    pend_dir_d    = take_valid ? take_dir : pend_dir_q;
    if (take_valid) begin
      pend_valid_d = 1'b1;
    end else if (tick) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      state_q       <= '0;
      state_prev_q  <= '0;
      press_q       <= '0;
      pend_valid_q  <= 1'b0;
      pend_dir_q    <= 2'd0;
      dir_q         <= INIT_DIR;
      dir_changed_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      state_prev_q  <= state_prev_d;
      press_q       <= press_d;
      pend_valid_q  <= pend_valid_d;
      pend_dir_q    <= pend_dir_d;
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_state   = state_q;
  assign press       = press_q;
  assign dir         = dir_q;
  assign dir_changed = dir_changed_q;

endmodule

// File: tb/tb_direction_input.sv
// ---------------------------------------------------------------------------
// tb_direction_input
//
// Self-checking bench for direction_input with DEBOUNCE_CYCLES=4, INIT_DIR=1.
// A behavioural model (raw history window, pending slot, heading) runs
// alongside the DUT and is compared every cycle; directed steps add fixed
// expectations for reset, bounce timing, commit, latest-wins, reversal and
// collision cases, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_direction_input;

  localparam int         DEBOUNCE_CYCLES = 4;
  localparam logic [1:0] INIT_DIR        = 2'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       tick;
  logic [3:0] btn_state;
  logic [3:0] press;
  logic [1:0] dir;
  logic       dir_changed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  direction_input #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INIT_DIR       (INIT_DIR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .tick       (tick),
    .btn_state  (btn_state),
    .press      (press),
    .dir        (dir),
    .dir_changed(dir_changed)
  );

  // Reference model. A level change is accepted once the synchronised input
  // (raw seen two edges earlier) has disagreed with the accepted level for
  // the last DEBOUNCE_CYCLES edges in a row.
  logic [3:0] rawDelay[$];
  logic [3:0] syncHist[$];
  logic [3:0] mState, mPress, mRoseLast;
  logic       mPendValid;
  int         mPendDir, mDir;
  logic       mChanged;

  logic [3:0] syncSeen, newState, pressBefore;
  bit         allDiffer, blocked;

  always @(posedge clk) begin
    if (rst) begin
      rawDelay.delete();
      syncHist.delete();
      mState     = 4'b0;
      mPress     = 4'b0;
      mRoseLast  = 4'b0;
      mPendValid = 1'b0;
      mPendDir   = 0;
      mDir       = int'(INIT_DIR);
      mChanged   = 1'b0;
    end else begin
      syncSeen = (rawDelay.size() == 2) ? rawDelay[0] : 4'b0;
      rawDelay.push_back(btn_raw);
      if (rawDelay.size() > 2) void'(rawDelay.pop_front());
      syncHist.push_back(syncSeen);
      if (syncHist.size() > DEBOUNCE_CYCLES) void'(syncHist.pop_front());

      newState = mState;
      for (int b = 0; b < 4; b++) begin
        allDiffer = (syncHist.size() == DEBOUNCE_CYCLES);
        foreach (syncHist[k]) if (syncHist[k][b] == mState[b]) allDiffer = 0;
        if (allDiffer) newState[b] = ~mState[b];
      end

      pressBefore = mPress;
      mPress      = mRoseLast;
      mRoseLast   = newState & ~mState;
      mState      = newState;

      mChanged = 1'b0;
      if (tick && mPendValid) begin
`ifdef DIR_REVERSAL_BLOCK_EN
        blocked = (mPendDir == (mDir + 2) % 4);
`else
        blocked = 0;
`endif
        if (!blocked) begin
          mChanged = (mPendDir != mDir);
          mDir     = mPendDir;
        end
      end

      if (pressBefore != 4'b0) begin
        mPendValid = 1'b1;
        for (int b = 3; b >= 0; b--) if (pressBefore[b]) mPendDir = b;
      end else if (tick) begin
        mPendValid = 1'b0;
      end
    end
  end

  task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("model.btn_state", btn_state, mState);
    checkValue("model.press", press, mPress);
    checkValue("model.dir", {2'b00, dir}, 4'(mDir));
    checkValue("model.dir_changed", {3'b000, dir_changed}, {3'b000, mChanged});
  endtask

  // Drive one cycle of inputs, then sample at the following negedge.
  task automatic applyStimulus(input logic [3:0] raw, input logic tk, input logic r);
    btn_raw = raw;
    tick    = tk;
    rst     = r;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic pressButtons(input logic [3:0] mask);
    for (int i = 0; i < 8; i++) applyStimulus(mask, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(4'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    for (int i = 0; i < 3; i++) applyStimulus(4'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int         pulses;
    int         holdLeft;
    logic [3:0] rawR;
    logic [3:0] expDir;

    btn_raw = 4'b0;
    tick    = 1'b0;
    rst     = 1'b1;

    // Reset
    doReset();
    checkValue("reset.dir", {2'b00, dir}, 4'd1);
    checkValue("reset.btn_state", btn_state, 4'b0);
    checkValue("reset.press", press, 4'b0);
    checkValue("reset.dir_changed", {3'b000, dir_changed}, 4'b0);

    // Bounce on N, then a clean hold
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      checkValue("bounce.no_press", press, 4'b0);
    end
    for (int n = 1; n <= 8; n++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0);
      if (press[0]) pulses++;
      checkValue($sformatf("bounce.state_edge%0d", n), {3'b000, btn_state[0]},
                 (n >= 6) ? 4'd1 : 4'd0);
      checkValue($sformatf("bounce.press_edge%0d", n), {3'b000, press[0]},
                 (n == 7) ? 4'd1 : 4'd0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0, 1'b0, 1'b0);
      if (press[0]) pulses++;
    end
    checkValue("bounce.pulse_count", 4'(pulses), 4'd1);

    // Commit S
    pressButtons(4'b0100);
    applyStimulus(4'b0, 1'b1, 1'b0);
    checkValue("commit.dir", {2'b00, dir}, 4'd2);
    checkValue("commit.changed", {3'b000, dir_changed}, 4'd1);
    applyStimulus(4'b0, 1'b0, 1'b0);
    checkValue("commit.changed_drop", {3'b000, dir_changed}, 4'd0);

    // Latest press wins
    pressButtons(4'b0001);
    pressButtons(4'b1000);
    applyStimulus(4'b0, 1'b1, 1'b0);
    checkValue("latest.dir", {2'b00, dir}, 4'd3);
    applyStimulus(4'b0, 1'b0, 1'b0);

    // Reversal from E
    doReset();
    checkValue("rev.start_dir", {2'b00, dir}, 4'd1);
    pressButtons(4'b1000);
    applyStimulus(4'b0, 1'b1, 1'b0);
`ifdef DIR_REVERSAL_BLOCK_EN
    checkValue("rev.dir", {2'b00, dir}, 4'd1);
    checkValue("rev.changed", {3'b000, dir_changed}, 4'd0);
    expDir = 4'd1;
`else
    checkValue("rev.dir", {2'b00, dir}, 4'd3);
    checkValue("rev.changed", {3'b000, dir_changed}, 4'd1);
    expDir = 4'd3;
`endif
    applyStimulus(4'b0, 1'b1, 1'b0);
    checkValue("rev.second_tick_dir", {2'b00, dir}, expDir);
    checkValue("rev.second_tick_changed", {3'b000, dir_changed}, 4'd0);

    // N+S together: N has priority
    pressButtons(4'b0101);
    applyStimulus(4'b0, 1'b1, 1'b0);
    checkValue("collide.ns_dir", {2'b00, dir}, 4'd0);

    // tick in the same cycle as press[2] with an empty slot
    for (int i = 0; i < 7; i++) applyStimulus(4'b0100, 1'b0, 1'b0);
    checkValue("collide.press_s", press, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkValue("collide.same_cycle_dir", {2'b00, dir}, 4'd0);
    checkValue("collide.same_cycle_changed", {3'b000, dir_changed}, 4'd0);
    for (int i = 0; i < 8; i++) applyStimulus(4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0, 1'b1, 1'b0);
`ifdef DIR_REVERSAL_BLOCK_EN
    checkValue("collide.next_tick_dir", {2'b00, dir}, 4'd0);
`else
    checkValue("collide.next_tick_dir", {2'b00, dir}, 4'd2);
`endif

    // Reset in the middle of a debounce count
    for (int i = 0; i < 4; i++) applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'b0, 1'b0, 1'b0);
      checkValue("midreset.press", press, 4'b0);
      checkValue("midreset.state", btn_state, 4'b0);
    end

    // Randomized phase against the model
    holdLeft = 0;
    rawR     = 4'b0;
    for (int c = 0; c < 3000; c++) begin
      if (holdLeft == 0) begin
        rawR     = 4'($urandom);
        holdLeft = $urandom_range(1, 12);
      end
      holdLeft--;
      applyStimulus(rawR, ($urandom_range(0, 7) == 0), ($urandom_range(0, 499) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
